// File: rtl/ahb_lite_cmd_master_if.sv
// Command/response stream plus AHB-Lite master signals for ahb_lite_cmd_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface ahb_lite_cmd_master_if #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_BUS_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic                      rsp_valid;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic [ADDR_BUS_WIDTH-1:0] HADDR;
  logic                      HWRITE;
  logic [1:0]                HTRANS;
  logic [2:0]                HSIZE;
  logic [DATA_WIDTH-1:0]     HWDATA;
  logic [DATA_WIDTH-1:0]     HRDATA;
  logic                      HREADY;
  logic                      HRESP;
  logic                      bus_hang;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HWRITE, HTRANS, HSIZE, HWDATA, bus_hang
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HWRITE, HTRANS, HSIZE, HWDATA, bus_hang
  );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-word master: valid/ready commands become pipelined NONSEQ transfers,
// one in-order response per command, two-cycle ERROR handling with replay, hang detection.
//
// state     | meaning
// S_RUN     | normal pipelined operation
// S_ERR     | first ERROR cycle seen, no address phase waiting behind it
// S_ERR_RPL | first ERROR cycle seen, held address phase is replayed after the error
module ahb_lite_cmd_master #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT        = 16
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  ahb_lite_cmd_master_if.master bus
);

  localparam int                AW             = ADDR_BUS_WIDTH;
  localparam int                CW             = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     HANG_MAX       = CW'(TIMEOUT);
  localparam logic [1:0]        HTRANS_IDLE    = 2'b00;
  localparam logic [1:0]        HTRANS_NONSEQ  = 2'b10;

  typedef enum logic [1:0] {S_RUN, S_ERR, S_ERR_RPL} state_t;

  state_t                r_state;
  logic                  r_ap_valid;
  logic [DATA_WIDTH-1:0] r_ap_wdata;
  logic                  r_dp_valid;
  logic                  r_dp_write;
  logic [AW-1:0]         r_haddr;
  logic                  r_hwrite;
  logic [1:0]            r_htrans;
  logic [DATA_WIDTH-1:0] r_hwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic [CW-1:0]         r_hang_cnt;
  logic                  r_bus_hang;

  logic w_cmd_ready;
  logic w_accept;

  assign w_cmd_ready = HRESETn & bus.HREADY & (r_state == S_RUN);
  assign w_accept    = bus.cmd_valid & w_cmd_ready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_RUN;
      r_ap_valid  <= 1'b0;
      r_ap_wdata  <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_htrans    <= HTRANS_IDLE;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_hang_cnt  <= '0;
      r_bus_hang  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      if (bus.HREADY) begin
        r_hang_cnt <= '0;
        if (r_dp_valid) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= bus.HRESP;
          r_rsp_rdata <= r_dp_write ? '0 : bus.HRDATA;
        end
        if (r_state != S_RUN) begin
          // The held address phase was presented as IDLE during the error, so it is
          // not promoted to the data phase; it goes back out as NONSEQ instead.
          r_state    <= S_RUN;
          r_dp_valid <= 1'b0;
          r_htrans   <= (r_state == S_ERR_RPL) ? HTRANS_NONSEQ : HTRANS_IDLE;
        end else begin
          r_dp_valid <= r_ap_valid;
          r_dp_write <= r_hwrite;
          if (r_ap_valid && r_hwrite) begin
            r_hwdata <= r_ap_wdata;
          end
          if (w_accept) begin
            r_ap_valid <= 1'b1;
            r_ap_wdata <= bus.cmd_wdata;
            r_haddr    <= bus.cmd_addr & ~AW'(3);
            r_hwrite   <= bus.cmd_write;
            r_htrans   <= HTRANS_NONSEQ;
          end else begin
            r_ap_valid <= 1'b0;
            r_htrans   <= HTRANS_IDLE;
          end
        end
      end else begin
        if ((r_ap_valid || r_dp_valid) && (r_hang_cnt != HANG_MAX)) begin
          r_hang_cnt <= r_hang_cnt + CW'(1);
          if (r_hang_cnt == HANG_MAX - CW'(1)) begin
            r_bus_hang <= 1'b1;
          end
        end
        if ((r_state == S_RUN) && r_dp_valid && bus.HRESP) begin
          r_state  <= r_ap_valid ? S_ERR_RPL : S_ERR;
          r_htrans <= HTRANS_IDLE;
        end
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.HADDR     = r_haddr;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HTRANS    = r_htrans;
  assign bus.HSIZE     = 3'b010;
  assign bus.HWDATA    = r_hwdata;
  assign bus.bus_hang  = r_bus_hang;

endmodule
